// File: rtl/sap_1_controller_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sap_1_controller_sequencer
//  Purpose  : SAP-1 ring-counter sequencer (T1..T6 + HALT). Builds the 12-bit
//             control word from the ring state and the one-hot decode lines.
//             It also flags HLT and undecodable opcodes.
//  Revision : 1.0 - initial release
// ============================================================================
module sap_1_controller_sequencer #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        run,
    input  logic        lda,
    input  logic        add,
    input  logic        sub,
    input  logic        out,
    input  logic        hlt,
    output logic [11:0] con,
    output logic [5:0]  t_state,
    output logic        halted,
    output logic        illegal_op
);

    typedef enum logic [2:0] {
        ST_T1   = 3'd0,
        ST_T2   = 3'd1,
        ST_T3   = 3'd2,
        ST_T4   = 3'd3,
        ST_T5   = 3'd4,
        ST_T6   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    // Control word bit order: Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo
    localparam logic [11:0] CON_NONE   = 12'h000;
    localparam logic [11:0] CON_FETCH1 = 12'h600;  // Ep, Lm
    localparam logic [11:0] CON_FETCH2 = 12'h800;  // Cp
    localparam logic [11:0] CON_FETCH3 = 12'h180;  // CE, Li
    localparam logic [11:0] CON_ADDR   = 12'h240;  // Ei, Lm
    localparam logic [11:0] CON_LDA5   = 12'h120;  // CE, La
    localparam logic [11:0] CON_LDB5   = 12'h102;  // CE, Lb
    localparam logic [11:0] CON_ADD6   = 12'h024;  // La, Eu
    localparam logic [11:0] CON_SUB6   = 12'h02C;  // La, Su, Eu
    localparam logic [11:0] CON_OUT4   = 12'h011;  // Ea, Lo

    state_t      state;
    state_t      state_next;
    logic        illegal_next;
    logic [11:0] con_raw;
    logic [4:0]  dec_lines;
    logic        op_legal;

    // A legal opcode has exactly one decode line high.
    assign dec_lines = {hlt, out, sub, add, lda};
    assign op_legal  = (dec_lines != 5'd0) &&
                       ((dec_lines & (dec_lines - 5'd1)) == 5'd0);

    // Ring state register and sticky illegal-opcode flag.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= ST_T1;
            illegal_op <= 1'b0;
        end else begin
            state      <= state_next;
            illegal_op <= illegal_next;
        end
    end

    // Next state: advance only with run high; T4 decides HALT entry.
    always_comb begin
        state_next   = state;
        illegal_next = illegal_op;
        if (run) begin
            case (state)
                ST_T1:   state_next = ST_T2;
                ST_T2:   state_next = ST_T3;
                ST_T3:   state_next = ST_T4;
                ST_T4: begin
                    if (!op_legal) begin
                        illegal_next = 1'b1;
                    end
                    if ((op_legal && hlt) || (!op_legal && HALT_ON_ILLEGAL)) begin
                        state_next = ST_HALT;
                    end else begin
                        state_next = ST_T5;
                    end
                end
                ST_T5:   state_next = ST_T6;
                ST_T6:   state_next = ST_T1;
                ST_HALT: state_next = ST_HALT;
                default: state_next = ST_T1;
            endcase
        end
    end

    // Control word from state; execute steps only for a legal opcode.
    always_comb begin
        con_raw = CON_NONE;
        case (state)
            ST_T1: con_raw = CON_FETCH1;
            ST_T2: con_raw = CON_FETCH2;
            ST_T3: con_raw = CON_FETCH3;
            ST_T4: begin
                if (op_legal) begin
                    if (lda || add || sub) con_raw = CON_ADDR;
                    else if (out)          con_raw = CON_OUT4;
                end
            end
            ST_T5: begin
                if (op_legal) begin
                    if (lda)             con_raw = CON_LDA5;
                    else if (add || sub) con_raw = CON_LDB5;
                end
            end
            ST_T6: begin
                if (op_legal) begin
                    if (add)      con_raw = CON_ADD6;
                    else if (sub) con_raw = CON_SUB6;
                end
            end
            default: con_raw = CON_NONE;
        endcase
    end

    // Strobes are suppressed while frozen or held in reset.
    assign con = (clr_n && run) ? con_raw : CON_NONE;

    // One-hot ring view; all zero in HALT.
    always_comb begin
        t_state = 6'b000000;
        case (state)
            ST_T1:   t_state = 6'b000001;
            ST_T2:   t_state = 6'b000010;
            ST_T3:   t_state = 6'b000100;
            ST_T4:   t_state = 6'b001000;
            ST_T5:   t_state = 6'b010000;
            ST_T6:   t_state = 6'b100000;
            default: t_state = 6'b000000;
        endcase
    end

    assign halted = (state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_sap_1_controller_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sap_1_controller_sequencer
//  Purpose  : Self-checking bench; two instances (NOP / HALT on illegal)
//             share all stimulus. Directed scenarios plus a random run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sap_1_controller_sequencer;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        run;
    logic [4:0]  dec;          // {hlt, out, sub, add, lda}
    logic [11:0] con0, con1;
    logic [5:0]  ts0, ts1;
    logic        h0, h1, il0, il1;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [4:0] D_LDA = 5'b00001;
    localparam logic [4:0] D_ADD = 5'b00010;
    localparam logic [4:0] D_SUB = 5'b00100;
    localparam logic [4:0] D_OUT = 5'b01000;
    localparam logic [4:0] D_HLT = 5'b10000;

    sap_1_controller_sequencer #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .clr_n(clr_n), .run(run),
        .lda(dec[0]), .add(dec[1]), .sub(dec[2]), .out(dec[3]), .hlt(dec[4]),
        .con(con0), .t_state(ts0), .halted(h0), .illegal_op(il0)
    );

    sap_1_controller_sequencer #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .clr_n(clr_n), .run(run),
        .lda(dec[0]), .add(dec[1]), .sub(dec[2]), .out(dec[3]), .hlt(dec[4]),
        .con(con1), .t_state(ts1), .halted(h1), .illegal_op(il1)
    );

    always #10 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: step number 1..6 (0 = halted) per instance, plus
    // the sticky illegal flag. Execute words come from a per-opcode table.
    // ------------------------------------------------------------------
    int m_phase [2];
    bit m_ill   [2];

    // rows: LDA, ADD, SUB, OUT, HLT ; columns: T4, T5, T6
    logic [11:0] exec_tbl [5][3] = '{
        '{12'h240, 12'h120, 12'h000},
        '{12'h240, 12'h102, 12'h024},
        '{12'h240, 12'h102, 12'h02C},
        '{12'h011, 12'h000, 12'h000},
        '{12'h000, 12'h000, 12'h000}
    };
    logic [11:0] fetch_tbl [3] = '{12'h600, 12'h800, 12'h180};

    function automatic logic [11:0] exp_con(int i);
        int op;
        if (!clr_n || !run || m_phase[i] == 0) return 12'h000;
        if (m_phase[i] <= 3) return fetch_tbl[m_phase[i] - 1];
        if ($countones(dec) != 1) return 12'h000;
        op = 0;
        for (int b = 0; b < 5; b++) if (dec[b]) op = b;
        return exec_tbl[op][m_phase[i] - 4];
    endfunction

    function automatic logic [5:0] exp_ts(int i);
        if (m_phase[i] == 0) return 6'd0;
        return 6'd1 << (m_phase[i] - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 1;
            m_ill[i]   = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit legal;
        legal = ($countones(dec) == 1);
        for (int i = 0; i < 2; i++) begin
            if (clr_n && run && m_phase[i] != 0) begin
                if (m_phase[i] == 4) begin
                    if (!legal) m_ill[i] = 1'b1;
                    if ((legal && dec[4]) || (!legal && i == 1)) m_phase[i] = 0;
                    else m_phase[i] = 5;
                end else begin
                    m_phase[i] = (m_phase[i] == 6) ? 1 : m_phase[i] + 1;
                end
            end
        end
    endtask

    // One clock: rising edge updates model, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        model_reset();
        tick();
        clr_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        clr_n = 1'b0; run = 1'b1; dec = D_LDA;
        model_reset();
        #1;
        n_checks++; if (con0 !== 12'h000) begin n_fail++; $display("FAIL reset_con: got %h expected 000", con0); end
        n_checks++; if (ts0 !== 6'h01) begin n_fail++; $display("FAIL reset_ts: got %h expected 01", ts0); end
        n_checks++; if (h0 !== 1'b0 || h1 !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b%b expected 00", h0, h1); end
        n_checks++; if (il0 !== 1'b0 || il1 !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b%b expected 00", il0, il1); end
        tick();
        #1;
        n_checks++; if (con0 !== 12'h000 || ts0 !== 6'h01) begin n_fail++; $display("FAIL reset_hold: got con %h ts %h expected 000 01", con0, ts0); end
        clr_n = 1'b1;
    endtask

    task automatic test_lda();
        logic [11:0] ec [7] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000, 12'h600};
        logic [5:0]  et [7] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
        run = 1'b1; dec = D_LDA;
        for (int i = 0; i < 7; i++) begin
            #1;
            n_checks++; if (con0 !== ec[i]) begin n_fail++; $display("FAIL lda_con[%0d]: got %h expected %h", i, con0, ec[i]); end
            n_checks++; if (ts0 !== et[i]) begin n_fail++; $display("FAIL lda_ts[%0d]: got %h expected %h", i, ts0, et[i]); end
            n_checks++; if (con1 !== ec[i]) begin n_fail++; $display("FAIL lda_con1[%0d]: got %h expected %h", i, con1, ec[i]); end
            if (i < 6) tick();
        end
    endtask

    task automatic test_add_sub();
        logic [11:0] ec [12] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h024,
                                 12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h02C};
        run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            dec = (i < 6) ? D_ADD : D_SUB;
            #1;
            n_checks++; if (con0 !== ec[i]) begin n_fail++; $display("FAIL addsub_con[%0d]: got %h expected %h", i, con0, ec[i]); end
            tick();
        end
    endtask

    task automatic test_out_hlt();
        logic [11:0] ec [10] = '{12'h600, 12'h800, 12'h180, 12'h011, 12'h000, 12'h000,
                                 12'h600, 12'h800, 12'h180, 12'h000};
        run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dec = (i < 6) ? D_OUT : D_HLT;
            #1;
            n_checks++; if (con0 !== ec[i]) begin n_fail++; $display("FAIL outhlt_con[%0d]: got %h expected %h", i, con0, ec[i]); end
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            run = 1'($urandom_range(0, 1));
            dec = 5'($urandom);
            #1;
            n_checks++; if (h0 !== 1'b1 || h1 !== 1'b1) begin n_fail++; $display("FAIL halt_flag[%0d]: got %b%b expected 11", i, h0, h1); end
            n_checks++; if (ts0 !== 6'h00 || con0 !== 12'h000) begin n_fail++; $display("FAIL halt_out[%0d]: got ts %h con %h expected 00 000", i, ts0, con0); end
            tick();
        end
        do_reset();
    endtask

    task automatic test_illegal();
        logic [11:0] ec [7] = '{12'h600, 12'h800, 12'h180, 12'h000, 12'h000, 12'h000, 12'h600};
        run = 1'b1; dec = 5'b00000;
        for (int i = 0; i < 7; i++) begin
            #1;
            n_checks++; if (con0 !== ec[i]) begin n_fail++; $display("FAIL illegal_con[%0d]: got %h expected %h", i, con0, ec[i]); end
            if (i == 3) begin
                n_checks++; if (il0 !== 1'b0) begin n_fail++; $display("FAIL illegal_early: got %b expected 0", il0); end
            end
            if (i >= 4) begin
                n_checks++; if (il0 !== 1'b1 || h0 !== 1'b0) begin n_fail++; $display("FAIL illegal_flag[%0d]: got il %b h %b expected 1 0", i, il0, h0); end
                n_checks++; if (h1 !== 1'b1 || il1 !== 1'b1 || ts1 !== 6'h00) begin n_fail++; $display("FAIL illegal_halt1[%0d]: got h %b il %b ts %h expected 1 1 00", i, h1, il1, ts1); end
            end
            if (i < 6) tick();
        end
        do_reset();
    endtask

    task automatic test_run_freeze();
        run = 1'b1; dec = D_LDA;
        tick(); tick();
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (ts0 !== 6'h04 || con0 !== 12'h000) begin n_fail++; $display("FAIL freeze[%0d]: got ts %h con %h expected 04 000", i, ts0, con0); end
            tick();
        end
        run = 1'b1;
        #1;
        n_checks++; if (con0 !== 12'h180 || ts0 !== 6'h04) begin n_fail++; $display("FAIL unfreeze: got con %h ts %h expected 180 04", con0, ts0); end
        tick();
        dec = D_LDA | D_ADD;
        #1;
        n_checks++; if (con0 !== 12'h000) begin n_fail++; $display("FAIL multi_con: got %h expected 000", con0); end
        tick();
        n_checks++; if (il0 !== 1'b1) begin n_fail++; $display("FAIL multi_illegal: got %b expected 1", il0); end
        for (int i = 0; i < 5; i++) tick();     // T5,T6,T1,T2,T3 -> T4
        dec = D_HLT; run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            n_checks++; if (h0 !== 1'b0 || ts0 !== 6'h08) begin n_fail++; $display("FAIL hlt_frozen[%0d]: got h %b ts %h expected 0 08", i, h0, ts0); end
        end
        run = 1'b1;
        tick();
        #1;
        n_checks++; if (h0 !== 1'b1 || ts0 !== 6'h00) begin n_fail++; $display("FAIL hlt_resume: got h %b ts %h expected 1 00", h0, ts0); end
        tick();
        do_reset();
    endtask

    task automatic test_async_reset();
        run = 1'b1; dec = 5'b00000;
        for (int i = 0; i < 6; i++) tick();     // illegal instruction sets flags
        dec = D_ADD;
        for (int i = 0; i < 4; i++) tick();     // now at T5 of ADD
        #1;
        n_checks++; if (con0 !== 12'h102 || il0 !== 1'b1 || h1 !== 1'b1) begin n_fail++; $display("FAIL pre_async: got con %h il %b h1 %b expected 102 1 1", con0, il0, h1); end
        #2;
        clr_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (con0 !== 12'h000 || ts0 !== 6'h01) begin n_fail++; $display("FAIL async_out: got con %h ts %h expected 000 01", con0, ts0); end
        n_checks++; if (il0 !== 1'b0 || il1 !== 1'b0 || h1 !== 1'b0 || ts1 !== 6'h01) begin n_fail++; $display("FAIL async_flags: got il %b%b h1 %b ts1 %h expected 00 0 01", il0, il1, h1, ts1); end
        #1;
        clr_n = 1'b1;
        #1;
        n_checks++; if (con0 !== 12'h600) begin n_fail++; $display("FAIL async_t1: got %h expected 600", con0); end
        tick();
        #1;
        n_checks++; if (con0 !== 12'h800 || ts0 !== 6'h02) begin n_fail++; $display("FAIL async_t2: got con %h ts %h expected 800 02", con0, ts0); end
        tick();
        #1;
        n_checks++; if (con0 !== 12'h180 || ts0 !== 6'h04) begin n_fail++; $display("FAIL async_t3: got con %h ts %h expected 180 04", con0, ts0); end
        tick();
        do_reset();
    endtask

    task automatic test_random();
        logic [4:0] instr;
        int         r;
        instr = D_LDA;
        for (int c = 0; c < 400; c++) begin
            run = ($urandom_range(0, 7) != 0);
            if (m_phase[0] == 1) begin
                r = $urandom_range(0, 7);
                if (r < 5)       instr = 5'd1 << r;
                else if (r == 5) instr = 5'd0;
                else             instr = 5'($urandom);
            end
            dec = (m_phase[0] >= 4) ? instr : 5'($urandom);
            #1;
            n_checks++; if (con0 !== exp_con(0)) begin n_fail++; $display("FAIL rnd_con0[%0d]: got %h expected %h", c, con0, exp_con(0)); end
            n_checks++; if (con1 !== exp_con(1)) begin n_fail++; $display("FAIL rnd_con1[%0d]: got %h expected %h", c, con1, exp_con(1)); end
            n_checks++; if (ts0 !== exp_ts(0) || ts1 !== exp_ts(1)) begin n_fail++; $display("FAIL rnd_ts[%0d]: got %h %h expected %h %h", c, ts0, ts1, exp_ts(0), exp_ts(1)); end
            n_checks++; if (h0 !== (m_phase[0] == 0) || h1 !== (m_phase[1] == 0)) begin n_fail++; $display("FAIL rnd_halted[%0d]: got %b%b expected %b%b", c, h0, h1, m_phase[0] == 0, m_phase[1] == 0); end
            n_checks++; if (il0 !== m_ill[0] || il1 !== m_ill[1]) begin n_fail++; $display("FAIL rnd_illegal[%0d]: got %b%b expected %b%b", c, il0, il1, m_ill[0], m_ill[1]); end
            tick();
            if (m_phase[0] == 0 || $urandom_range(0, 63) == 0) do_reset();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n = 1'b0; run = 1'b0; dec = 5'd0;
        test_reset();
        test_lda();
        test_add_sub();
        test_out_hlt();
        test_illegal();
        test_run_freeze();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sap_1_controller_sequencer.md
Name: sap_1_controller_sequencer

Overview:
- Downstream consumer of the SAP-1 instruction decoder's one-hot opcode lines (LDA, ADD, SUB, OUT, HLT).
- Runs the fixed 6-state ring counter T1..T6 and produces the 12-bit SAP-1 control word that drives PC, MAR, RAM, IR, A, ALU, B and output register.
- Also detects HLT and undecodable opcodes.

Parameters:
- HALT_ON_ILLEGAL, 0: when 1, an illegal opcode at T4 enters HALT as well as setting illegal_op; when 0, it executes as NOP.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr_n  input  1  reset, asynchronous, active-low.
- run  input  1  sequencer enable; low freezes the ring counter.
- lda  input  1  decoded LDA (opcode 0000), from instruction decoder.
- add  input  1  decoded ADD (0001).
- sub  input  1  decoded SUB (0010).
- out  input  1  decoded OUT (1110).
- hlt  input  1  decoded HLT (1111).
- con  output  12  control word, all bits active-high: [11]Cp [10]Ep [9]Lm [8]CE [7]Li [6]Ei [5]La [4]Ea [3]Su [2]Eu [1]Lb [0]Lo.
- t_state  output  6  one-hot ring state; bit0=T1 .. bit5=T6; 0 in HALT.
- halted  output  1  high in HALT.
- illegal_op  output  1  sticky flag, set on an illegal opcode at T4.

Behaviour:
- One clock domain. Reset is asynchronous and active-low on clr_n.
- Reset (clr_n=0): state=T1, t_state=6'b000001, halted=0, illegal_op=0, con forced to 12'h000 for as long as clr_n is low.
- States: T1..T6 and HALT.
- Transitions, on each rising edge with run=1:
  - T1->T2->T3->T4->T5->T6->T1.
  - T4 with hlt (legal) -> HALT.
  - HALT is absorbing until reset.
- run=0: state holds and con=12'h000; no strobe may repeat while frozen.
- con is combinational from state and the decode lines, with run=1 and clr_n=1. Decode lines are valid from T4 onward; IR is stable by then.
- Fetch, all opcodes:
  - T1: Ep,Lm (0x600).
  - T2: Cp (0x800).
  - T3: CE,Li (0x180).
- Execute:
  - LDA: T4 Ei,Lm (0x240); T5 CE,La (0x120); T6 none.
  - ADD: T4 0x240; T5 CE,Lb (0x102); T6 La,Eu (0x024).
  - SUB: T4 0x240; T5 0x102; T6 La,Su,Eu (0x02C).
  - OUT: T4 Ea,Lo (0x011); T5 none; T6 none.
  - HLT: T4 con=0; next edge enters HALT (halted=1, t_state=0, con=0).
- Legal opcode = exactly one of lda/add/sub/out/hlt high.
- Illegal opcode = zero lines high (opcodes 0011..1101) or more than one line high.
  - At T4: illegal_op set on that edge.
  - T4..T6 then run with con=0 (NOP), or the block enters HALT when HALT_ON_ILLEGAL=1.
  - illegal_op stays set until reset.
- Decode lines are ignored in T1..T3; illegal patterns there have no effect.
- run=0 during T4 with hlt high: no transition. HALT is entered on the first edge with run=1.
- Reset asserted mid-instruction: immediate return to the reset values above. Execution resumes at T1 on the first rising edge after clr_n deasserts, and that edge advances to T2.
- No counter wrap beyond T6. t_state is always one-hot or zero, never any other value.

Test Plan:
- Reset then run=1, lda=1: con sequence per cycle 0x600,0x800,0x180,0x240,0x120,0x000, then 0x600 again; t_state walks 01,02,04,08,10,20,01.
- add=1 for one instruction, then sub=1 for the next: T5=0x102 for both; T6=0x024 for ADD, 0x02C for SUB; the fetch between them is unchanged.
- out=1: T4=0x011, T5=0x000, T6=0x000. Then hlt=1: T4=0x000, next edge halted=1, t_state=0, con=0 for 10+ cycles, ignoring run/decode toggling.
- All decode lines low at T4 (opcode 0101), HALT_ON_ILLEGAL=0: illegal_op rises after the T4 edge, T4..T6 con=0, the next T1 is 0x600. Repeat with HALT_ON_ILLEGAL=1: halted=1 after T4.
- run dropped at T3 for 3 cycles: t_state holds 04, con=0x000; on run=1 con=0x180 and the sequence continues. Also lda+add high together at T4 -> illegal_op=1.
- clr_n pulsed low asynchronously (mid-cycle) at T5 of ADD: con=0 and t_state=01 immediately, without waiting for a clk edge; illegal_op/halted cleared; after release the normal fetch restarts at T1.
